// File: rtl/sm3_pkg.sv
// -----------------------------------------------------------------------------
// sm3_pkg
// Shared definitions for the SM3 blocks.
//   INPT_DW      : message-input width of the compression core (32 or 64).
//                  Define SM3_INPT_DW_64 (normally set in sm3_cfg.v) for 64.
//   BYTE_NUM     : bytes per core input word.
//   MAX_BYTE_NUM : bytes per word of the widest supported core.
//   f_vld_byte_mask(n) : left-justified valid-byte mask with n bits set.
// -----------------------------------------------------------------------------
package sm3_pkg;

`ifdef SM3_INPT_DW_64
    localparam int INPT_DW = 64;
`else
    localparam int INPT_DW = 32;
`endif

    localparam int BYTE_NUM     = INPT_DW / 8;
    localparam int MAX_BYTE_NUM = 8;

    // The mask is built left-justified in the widest core's mask so that one
    // function serves both core widths; a narrower core takes its top
    // BYTE_NUM bits (shift right by MAX_BYTE_NUM-BYTE_NUM and truncate).
    function automatic logic [MAX_BYTE_NUM-1:0] f_vld_byte_mask(input int n);
        logic [MAX_BYTE_NUM-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BYTE_NUM; i++) begin
            if (i < n) begin
                mask[MAX_BYTE_NUM-1-i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sm3_msg_inpt_pkr.sv
// -----------------------------------------------------------------------------
// sm3_msg_inpt_pkr
// Byte-stream front end for sm3_core_top. Packs one byte per cycle, MSB-first,
// into INPT_DW-bit words and presents them on the core's message-input port.
// A pack register (with a "held word" flag) and a single output slot let the
// byte source keep streaming while the core stalls for up to one word.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   byte_d/vld/lst      : incoming message byte, valid, last byte of message
//   byte_rdy            : packer accepts a byte (registered, = no held word)
//   msg_inpt_d          : packed word, first byte in the top byte lane
//   msg_inpt_vld_byte   : left-justified valid-byte mask
//   msg_inpt_vld/lst    : word valid / word carries the final message byte
//   msg_inpt_rdy        : core accepts the word
//   pkr_idle            : no partial word, no held word, no pending output
// -----------------------------------------------------------------------------
module sm3_msg_inpt_pkr
    import sm3_pkg::*;
#(
    parameter int INPT_DW = sm3_pkg::INPT_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_d,
    input  logic                   byte_vld,
    input  logic                   byte_lst,
    output logic                   byte_rdy,
    output logic [INPT_DW-1:0]     msg_inpt_d,
    output logic [INPT_DW/8-1:0]   msg_inpt_vld_byte,
    output logic                   msg_inpt_vld,
    output logic                   msg_inpt_lst,
    input  logic                   msg_inpt_rdy,
    output logic                   pkr_idle
);

    localparam int BYTE_NUM = INPT_DW / 8;
    localparam int CNT_W    = $clog2(BYTE_NUM);

    if (INPT_DW != 32 && INPT_DW != 64) begin : g_bad_inpt_dw
        $error("sm3_msg_inpt_pkr: INPT_DW must be 32 or 64");
    end

    logic [INPT_DW-1:0]  pkWord_q,  pkWord_d;
    logic [BYTE_NUM-1:0] pkMask_q,  pkMask_d;
    logic                pkLst_q,   pkLst_d;
    logic                pkFull_q,  pkFull_d;
    logic [CNT_W-1:0]    byteCnt_q, byteCnt_d;

    logic [INPT_DW-1:0]  outWord_q, outWord_d;
    logic [BYTE_NUM-1:0] outMask_q, outMask_d;
    logic                outLst_q,  outLst_d;
    logic                outVld_q,  outVld_d;

    logic                accept;
    logic                xfer;
    logic                slotFree;
    logic                lastInWord;
    logic [INPT_DW-1:0]  mergedWord;
    logic [BYTE_NUM-1:0] mergedMask;

    // Next-state logic. A held word always has priority over new bytes (new
    // bytes are blocked anyway while it is held). A completed word goes
    // straight to the slot whenever the slot empties on the same edge,
    // otherwise it parks in the pack register.
    // The pack register is zeroed whenever its word leaves, so OR-ing the new
    // byte into its lane leaves the unused trailing bytes at zero.
    always_comb begin
        accept     = byte_vld && !pkFull_q;
        xfer       = outVld_q && msg_inpt_rdy;
        slotFree   = !outVld_q || xfer;
        lastInWord = (byteCnt_q == CNT_W'(BYTE_NUM - 1)) || byte_lst;
        mergedWord = pkWord_q |
                     ({byte_d, {(INPT_DW-8){1'b0}}} >> {byteCnt_q, 3'b000});
        mergedMask = BYTE_NUM'(f_vld_byte_mask(int'(byteCnt_q) + 1)
                               >> (MAX_BYTE_NUM - BYTE_NUM));

        pkWord_d  = pkWord_q;
        pkMask_d  = pkMask_q;
        pkLst_d   = pkLst_q;
        pkFull_d  = pkFull_q;
        byteCnt_d = byteCnt_q;
        outWord_d = outWord_q;
        outMask_d = outMask_q;
        outLst_d  = outLst_q;
        outVld_d  = outVld_q && !xfer;

        if (pkFull_q) begin
            if (slotFree) begin
                outWord_d = pkWord_q;
                outMask_d = pkMask_q;
                outLst_d  = pkLst_q;
                outVld_d  = 1'b1;
                pkFull_d  = 1'b0;
                pkWord_d  = '0;
            end
        end else if (accept) begin
            if (lastInWord) begin
                byteCnt_d = '0;
                if (slotFree) begin
                    outWord_d = mergedWord;
                    outMask_d = mergedMask;
                    outLst_d  = byte_lst;
                    outVld_d  = 1'b1;
                    pkWord_d  = '0;
                end else begin
                    pkWord_d  = mergedWord;
                    pkMask_d  = mergedMask;
                    pkLst_d   = byte_lst;
                    pkFull_d  = 1'b1;
                end
            end else begin
                pkWord_d  = mergedWord;
                byteCnt_d = byteCnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any partial, held or pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkWord_q  <= '0;
            pkMask_q  <= '0;
            pkLst_q   <= 1'b0;
            pkFull_q  <= 1'b0;
            byteCnt_q <= '0;
            outWord_q <= '0;
            outMask_q <= '0;
            outLst_q  <= 1'b0;
            outVld_q  <= 1'b0;
        end else begin
            pkWord_q  <= pkWord_d;
            pkMask_q  <= pkMask_d;
            pkLst_q   <= pkLst_d;
            pkFull_q  <= pkFull_d;
            byteCnt_q <= byteCnt_d;
            outWord_q <= outWord_d;
            outMask_q <= outMask_d;
            outLst_q  <= outLst_d;
            outVld_q  <= outVld_d;
        end
    end

    assign byte_rdy          = !pkFull_q;
    assign msg_inpt_d        = outWord_q;
    assign msg_inpt_vld_byte = outMask_q;
    assign msg_inpt_vld      = outVld_q;
    assign msg_inpt_lst      = outLst_q;
    assign pkr_idle          = (byteCnt_q == '0) && !pkFull_q && !outVld_q;

endmodule

// File: tb/tb_sm3_msg_inpt_pkr.sv
// -----------------------------------------------------------------------------
// tb_sm3_msg_inpt_pkr
// Drives a 32-bit and a 64-bit packer (one active at a time, chosen by sel)
// with directed and random byte streams. A reference model packs the accepted
// byte stream into words and tracks how many finished words sit inside the
// packer, from which vld/rdy/idle and every transferred word are predicted.
// -----------------------------------------------------------------------------
module tb_sm3_msg_inpt_pkr;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  m;
        logic        l;
    } word_t;

    logic        clk;
    logic        rst;
    logic [7:0]  byteD;
    logic        byteVld;
    logic        byteLst;
    logic        msgRdy;
    logic        sel;
    int          rdyMode;

    logic        byteVld32, byteRdy32, vld32, lst32, idle32;
    logic [31:0] data32;
    logic [3:0]  mask32;
    logic        byteVld64, byteRdy64, vld64, lst64, idle64;
    logic [63:0] data64;
    logic [7:0]  mask64;

    logic        curByteRdy, curVld, curLst, curIdle;
    logic [63:0] curData;
    logic [7:0]  curMask;
    int          curBytes;

    int          checks;
    int          errors;

    word_t       expQ[$];
    int          outstanding;
    int          partCnt;
    logic [63:0] partWord;
    logic [7:0]  partMask;

    assign byteVld32 = byteVld & ~sel;
    assign byteVld64 = byteVld & sel;

    assign curByteRdy = sel ? byteRdy64 : byteRdy32;
    assign curVld     = sel ? vld64 : vld32;
    assign curLst     = sel ? lst64 : lst32;
    assign curIdle    = sel ? idle64 : idle32;
    assign curData    = sel ? data64 : {data32, 32'h0};
    assign curMask    = sel ? mask64 : {mask32, 4'h0};
    assign curBytes   = sel ? 8 : 4;

    sm3_msg_inpt_pkr #(.INPT_DW(32)) dut32 (
        .clk               (clk),
        .rst               (rst),
        .byte_d            (byteD),
        .byte_vld          (byteVld32),
        .byte_lst          (byteLst),
        .byte_rdy          (byteRdy32),
        .msg_inpt_d        (data32),
        .msg_inpt_vld_byte (mask32),
        .msg_inpt_vld      (vld32),
        .msg_inpt_lst      (lst32),
        .msg_inpt_rdy      (msgRdy),
        .pkr_idle          (idle32)
    );

    sm3_msg_inpt_pkr #(.INPT_DW(64)) dut64 (
        .clk               (clk),
        .rst               (rst),
        .byte_d            (byteD),
        .byte_vld          (byteVld64),
        .byte_lst          (byteLst),
        .byte_rdy          (byteRdy64),
        .msg_inpt_d        (data64),
        .msg_inpt_vld_byte (mask64),
        .msg_inpt_vld      (vld64),
        .msg_inpt_lst      (lst64),
        .msg_inpt_rdy      (msgRdy),
        .pkr_idle          (idle64)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sink behaviour: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (rdyMode)
            0:       msgRdy = 1'b1;
            1:       msgRdy = 1'($urandom_range(0, 1));
            default: msgRdy = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        outstanding = 0;
        partCnt     = 0;
        partWord    = '0;
        partMask    = '0;
    endtask

    // Reference model and monitor. At each falling edge the state left by the
    // previous rising edge is checked, then the handshakes that the next
    // rising edge will complete are applied to the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("msg_inpt_vld", 64'(curVld), 64'(outstanding > 0));
            checkOutput("byte_rdy", 64'(curByteRdy), 64'(outstanding < 2));
            checkOutput("pkr_idle", 64'(curIdle), 64'(outstanding == 0 && partCnt == 0));
            if (curVld && msgRdy) begin
                checkOutput("word_expected", 64'(expQ.size() > 0), 64'(1));
                if (expQ.size() > 0) begin
                    word_t w;
                    w = expQ.pop_front();
                    checkOutput("msg_inpt_d", curData, w.d);
                    checkOutput("msg_inpt_vld_byte", 64'(curMask), 64'(w.m));
                    checkOutput("msg_inpt_lst", 64'(curLst), 64'(w.l));
                end
                if (outstanding > 0) outstanding--;
            end
            if (byteVld && curByteRdy) begin
                partWord = partWord | ({byteD, 56'h0} >> (8 * partCnt));
                partMask = partMask | (8'h80 >> partCnt);
                partCnt++;
                if (partCnt == curBytes || byteLst) begin
                    expQ.push_back('{d: partWord, m: partMask, l: byteLst});
                    outstanding++;
                    partCnt  = 0;
                    partWord = '0;
                    partMask = '0;
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one byte and holds it until the packer takes it (bounded).
    task automatic applyStimulus(input logic [7:0] b, input logic l);
        int waitCnt;
        waitCnt = 0;
        byteD   = b;
        byteLst = l;
        byteVld = 1'b1;
        @(negedge clk);
        while (!curByteRdy && waitCnt < 100) begin
            waitCnt++;
            @(negedge clk);
        end
        checkOutput("byte_accept_in_time", 64'(waitCnt < 100), 64'(1));
        @(posedge clk);
        #1;
        byteVld = 1'b0;
        byteLst = 1'b0;
    endtask

    task automatic sendMessage(input int len, input int maxGap);
        for (int i = 0; i < len; i++) begin
            applyStimulus(8'($urandom), i == len - 1);
            if (maxGap > 0) idleCycles($urandom_range(0, maxGap));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        rdyMode = 0;
        while ((expQ.size() != 0 || outstanding != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        idleCycles(2);
        checkOutput("drain_in_time", 64'(n < 200), 64'(1));
    endtask

    task automatic checkReset();
        checkOutput("rst_msg_inpt_vld", 64'(curVld), 64'(0));
        checkOutput("rst_msg_inpt_lst", 64'(curLst), 64'(0));
        checkOutput("rst_msg_inpt_d", curData, 64'(0));
        checkOutput("rst_msg_inpt_vld_byte", 64'(curMask), 64'(0));
        checkOutput("rst_byte_rdy", 64'(curByteRdy), 64'(1));
        checkOutput("rst_pkr_idle", 64'(curIdle), 64'(1));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        byteD   = '0;
        byteVld = 1'b0;
        byteLst = 1'b0;
        msgRdy  = 1'b0;
        sel     = 1'b0;
        rdyMode = 0;
        modelReset();

        idleCycles(3);
        checkReset();
        #2 rst = 1'b0;

        // "abc"
        applyStimulus(8'h61, 1'b0);
        applyStimulus(8'h62, 1'b0);
        applyStimulus(8'h63, 1'b1);
        waitDrain();

        // 64 bytes of "abcd", sink always ready
        for (int i = 0; i < 64; i++) begin
            applyStimulus(8'h61 + 8'(i % 4), i == 63);
        end
        waitDrain();

        // Backpressure: two words queued behind a stalled sink
        rdyMode = 2;
        idleCycles(2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h10 + 8'(i), i == 7);
        end
        idleCycles(20);
        waitDrain();

        // Back-to-back messages of 5 and 1 bytes
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'hB0 + 8'(i), i == 4);
        end
        applyStimulus(8'hC0, 1'b1);
        waitDrain();

        // Random lengths, gaps and sink readiness
        rdyMode = 1;
        for (int m = 0; m < 40; m++) begin
            sendMessage($urandom_range(1, 12), $urandom_range(0, 2));
        end
        waitDrain();

        // Reset with a full slot and a partial word
        rdyMode = 2;
        idleCycles(2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hE0 + 8'(i), 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        checkReset();
        modelReset();
        rdyMode = 0;
        idleCycles(2);
        #2 rst = 1'b0;
        sendMessage(6, 0);
        waitDrain();

        // 64-bit core: bytes 01..09, then random traffic
        sel = 1'b1;
        idleCycles(1);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(8'(i), i == 9);
        end
        waitDrain();
        rdyMode = 1;
        for (int m = 0; m < 12; m++) begin
            sendMessage($urandom_range(1, 20), $urandom_range(0, 1));
        end
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
